// File: rtl/riscv_m_pkg.sv
// ----------------------------------------------------------------------------
// riscv_m_pkg
// Shared definitions for the iterative RV32M multiply/divide unit.
//  - XLEN          : default operand/result width
//  - FUNCT3_*      : M-extension op encodings carried on funct3
//  - mdu_state_t   : FSM state encoding used by mdu_seq
//  - rs1_signed / rs2_signed : which operand is treated as two's complement
// No ports (package).
// ----------------------------------------------------------------------------
package riscv_m_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] FUNCT3_MUL    = 3'd0;
   localparam logic [2:0] FUNCT3_MULH   = 3'd1;
   localparam logic [2:0] FUNCT3_MULHSU = 3'd2;
   localparam logic [2:0] FUNCT3_MULHU  = 3'd3;
   localparam logic [2:0] FUNCT3_DIV    = 3'd4;
   localparam logic [2:0] FUNCT3_DIVU   = 3'd5;
   localparam logic [2:0] FUNCT3_REM    = 3'd6;
   localparam logic [2:0] FUNCT3_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIN  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_t;

   // rs1 is signed for MUL, MULH, MULHSU, DIV and REM.
   function automatic logic rs1_signed(input logic [2:0] f3);
      return (f3 == FUNCT3_MUL) || (f3 == FUNCT3_MULH) || (f3 == FUNCT3_MULHSU) ||
             (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
   endfunction

   // rs2 is signed for MUL, MULH, DIV and REM (MULHSU keeps rs2 unsigned).
   function automatic logic rs2_signed(input logic [2:0] f3);
      return (f3 == FUNCT3_MUL) || (f3 == FUNCT3_MULH) ||
             (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
   endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// ----------------------------------------------------------------------------
// mdu_seq_if
// Request/response bundle between the execute stage and the M-extension unit.
//  Request  : start, kill, funct3[2:0], rs1[XLEN-1:0], rs2[XLEN-1:0], dest[4:0]
//  Response : busy, done, result[XLEN-1:0], dest_out[4:0], wr_en
//  master modport drives requests (pipeline side); slave modport is the unit.
// ----------------------------------------------------------------------------
interface mdu_seq_if #(parameter int XLEN = 32);

   logic            start;
   logic            kill;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic [4:0]      dest;

   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      dest_out;
   logic            wr_en;

   modport master (
      output start, kill, funct3, rs1, rs2, dest,
      input  busy, done, result, dest_out, wr_en
   );

   modport slave (
      input  start, kill, funct3, rs1, rs2, dest,
      output busy, done, result, dest_out, wr_en
   );

endinterface

// File: rtl/mdu_result_fix.sv
// ----------------------------------------------------------------------------
// mdu_result_fix
// Combinational final stage of the multiply/divide unit: restores signs on the
// magnitude results and selects the value returned for the op.
//  product[2*XLEN-1:0]  : unsigned magnitude product
//  quotient[XLEN-1:0]   : unsigned magnitude quotient
//  remainder[XLEN-1:0]  : unsigned magnitude remainder
//  sign_a, sign_b       : operand sign flags (already zero for unsigned ops)
//  div_zero, div_ovf    : divide-by-zero and signed-overflow flags
//  funct3[2:0]          : op select
//  result[XLEN-1:0]     : final architectural value
// ----------------------------------------------------------------------------
module mdu_result_fix
   import riscv_m_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2*XLEN-1:0] product,
   input  logic [XLEN-1:0]   quotient,
   input  logic [XLEN-1:0]   remainder,
   input  logic              sign_a,
   input  logic              sign_b,
   input  logic              div_zero,
   input  logic              div_ovf,
   input  logic [2:0]        funct3,
   output logic [XLEN-1:0]   result
);

   logic              neg_res;
   logic [2*XLEN-1:0] prod_fixed;
   logic [XLEN-1:0]   quo_fixed;
   logic [XLEN-1:0]   rem_fixed;

   // Product and quotient take the sign of sA^sB, the remainder takes the
   // sign of the dividend. The whole 2*XLEN product is negated so that both
   // the low half (MUL) and the high half (MULH family) come out right.
   // For a zero divisor the raw remainder equals |rs1|, so sign-fixing it
   // reproduces rs1 exactly, including -2^(XLEN-1).
   always_comb begin
      neg_res    = sign_a ^ sign_b;
      prod_fixed = neg_res ? (~product + {{(2*XLEN-1){1'b0}}, 1'b1}) : product;
      quo_fixed  = neg_res ? (~quotient + {{(XLEN-1){1'b0}}, 1'b1}) : quotient;
      rem_fixed  = sign_a ? (~remainder + {{(XLEN-1){1'b0}}, 1'b1}) : remainder;
      result     = '0;
      case (funct3)
         FUNCT3_MUL: begin
            result = prod_fixed[XLEN-1:0];
         end
         FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: begin
            result = prod_fixed[2*XLEN-1:XLEN];
         end
         FUNCT3_DIV, FUNCT3_DIVU: begin
            if (div_zero)
               result = '1;
            else if (div_ovf)
               result = {1'b1, {(XLEN-1){1'b0}}};
            else
               result = quo_fixed;
         end
         FUNCT3_REM, FUNCT3_REMU: begin
            if (div_zero)
               result = rem_fixed;
            else if (div_ovf)
               result = '0;
            else
               result = rem_fixed;
         end
         default: begin
            result = '0;
         end
      endcase
   end

endmodule

// File: rtl/mdu_seq.sv
// ----------------------------------------------------------------------------
// mdu_seq
// Iterative RV32M multiply/divide unit. One op in flight, constant latency:
// start accepted in cycle 0 produces a one-cycle done in cycle XLEN+2.
//  clk          : clock, rising edge
//  rst          : synchronous, active-low reset
//  bus (slave)  : start/kill/funct3/rs1/rs2/dest in,
//                 busy/done/result/dest_out/wr_en out
// ----------------------------------------------------------------------------
module mdu_seq
   import riscv_m_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic     clk,
   input  logic     rst,
   mdu_seq_if.slave bus
);

   localparam int CNT_W = $clog2(XLEN);

   mdu_state_t       state;
   logic [CNT_W-1:0] cnt;

   logic [2:0]       op_f3;
   logic [4:0]       op_dest;
   logic             sign_a;
   logic             sign_b;
   logic             div_zero;
   logic             div_ovf;

   // acc_hi: upper product / partial remainder, one extra bit for the carry
   // acc_lo: multiplier shifting out + product low bits shifting in, or
   //         dividend shifting out + quotient bits shifting in
   // opb   : multiplicand / divisor magnitude
   logic [XLEN:0]    acc_hi;
   logic [XLEN-1:0]  acc_lo;
   logic [XLEN:0]    opb;

   logic             busy_r;
   logic             done_r;
   logic [XLEN-1:0]  result_r;
   logic [4:0]       dest_r;

   logic             a_neg;
   logic             b_neg;
   logic [XLEN-1:0]  a_mag;
   logic [XLEN:0]    b_mag;

   logic [XLEN:0]    mul_sum;
   logic [XLEN:0]    div_shift;
   logic [XLEN:0]    div_diff;
   logic             div_fits;

   logic [XLEN-1:0]  fix_result;

   // Operand conditioning at accept time: sign flags and magnitudes. An
   // unsigned XLEN-bit magnitude already holds 2^(XLEN-1) for rs1; the
   // divisor/multiplicand is carried in XLEN+1 bits to line up with acc_hi.
   always_comb begin
      a_neg = rs1_signed(bus.funct3) & bus.rs1[XLEN-1];
      b_neg = rs2_signed(bus.funct3) & bus.rs2[XLEN-1];
      a_mag = a_neg ? (~bus.rs1 + {{(XLEN-1){1'b0}}, 1'b1}) : bus.rs1;
      b_mag = b_neg ? ({1'b0, ~bus.rs2} + {{XLEN{1'b0}}, 1'b1}) : {1'b0, bus.rs2};
   end

   // One radix-2 step of each algorithm, computed every cycle; the FSM picks
   // which one to commit from op_f3[2] (set for the divide family).
   // Multiply adds the multiplicand when the current multiplier bit is set,
   // then the {acc_hi, acc_lo} pair shifts right by one.
   // Divide shifts the next dividend bit into the partial remainder and
   // subtracts the divisor only if it fits (restoring division).
   always_comb begin
      mul_sum   = acc_lo[0] ? (acc_hi + opb) : acc_hi;
      div_shift = {acc_hi[XLEN-1:0], acc_lo[XLEN-1]};
      div_fits  = (div_shift >= opb);
      div_diff  = div_shift - opb;
   end

   mdu_result_fix #(
      .XLEN(XLEN)
   ) u_fix (
      .product   ({acc_hi[XLEN-1:0], acc_lo}),
      .quotient  (acc_lo),
      .remainder (acc_hi[XLEN-1:0]),
      .sign_a    (sign_a),
      .sign_b    (sign_b),
      .div_zero  (div_zero),
      .div_ovf   (div_ovf),
      .funct3    (op_f3),
      .result    (fix_result)
   );

   // Main FSM with the datapath registers and registered outputs.
   // IDLE and DONE both accept a new op, which allows back-to-back issue from
   // the done cycle. kill wins over everything but reset: it drops a start in
   // the same cycle and abandons CALC/FIN without touching result/dest_out.
   // done is a one-cycle pulse: it is set on the FIN->DONE edge and cleared
   // by the default assignment on the following edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         op_f3    <= '0;
         op_dest  <= '0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         div_zero <= 1'b0;
         div_ovf  <= 1'b0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         opb      <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= '0;
         dest_r   <= '0;
      end else begin
         done_r <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (bus.start && !bus.kill) begin
                  op_f3    <= bus.funct3;
                  op_dest  <= bus.dest;
                  sign_a   <= a_neg;
                  sign_b   <= b_neg;
                  div_zero <= (bus.rs2 == '0);
                  div_ovf  <= ((bus.funct3 == FUNCT3_DIV) || (bus.funct3 == FUNCT3_REM)) &&
                              (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                              (bus.rs2 == '1);
                  acc_hi   <= '0;
                  acc_lo   <= a_mag;
                  opb      <= b_mag;
                  cnt      <= '0;
                  busy_r   <= 1'b1;
                  state    <= ST_CALC;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_CALC: begin
               if (bus.kill) begin
                  busy_r <= 1'b0;
                  state  <= ST_IDLE;
               end else begin
                  if (op_f3[2]) begin
                     acc_hi <= div_fits ? div_diff : div_shift;
                     acc_lo <= {acc_lo[XLEN-2:0], div_fits};
                  end else begin
                     acc_hi <= {1'b0, mul_sum[XLEN:1]};
                     acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                  end
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_W'(XLEN-1))
                     state <= ST_FIN;
               end
            end
            ST_FIN: begin
               if (bus.kill) begin
                  busy_r <= 1'b0;
                  state  <= ST_IDLE;
               end else begin
                  result_r <= fix_result;
                  dest_r   <= op_dest;
                  done_r   <= 1'b1;
                  busy_r   <= 1'b0;
                  state    <= ST_DONE;
               end
            end
            default: begin
               busy_r <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.wr_en    = done_r;
   assign bus.result   = result_r;
   assign bus.dest_out = dest_r;

endmodule

// File: tb/tb_mdu_seq.sv
// ----------------------------------------------------------------------------
// tb_mdu_seq
// Scoreboard bench for mdu_seq. The driver pushes the hand-computed result,
// dest and expected done cycle for every op it issues; a monitor process
// pops and compares whenever done is seen. Aborted ops push nothing, so any
// done they produce shows up as an unexpected response.
// ----------------------------------------------------------------------------
module tb_mdu_seq;
   import riscv_m_pkg::*;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  dest;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        prev_done = 1'b0;
   logic [31:0] last_res = '0;
   logic [4:0]  last_dest = '0;

   mdu_seq_if #(.XLEN(32)) bus ();

   mdu_seq #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Free-running clock and a cycle counter used for latency checks.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single comparison point: counts every check and reports failures.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Wait, on falling edges, until the unit can accept a request.
   task automatic waitIdle();
      int n = 0;
      @(negedge clk);
      while (bus.busy === 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) checkOutput("idle_timeout", 32'(bus.busy), 32'd0);
   endtask

   // Issue one op for a single cycle without registering an expectation.
   task automatic issueRaw(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] d, output int start_cyc);
      waitIdle();
      bus.funct3 = f3;
      bus.rs1    = a;
      bus.rs2    = b;
      bus.dest   = d;
      bus.start  = 1'b1;
      start_cyc  = cyc;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.rs1    = ~a;
      bus.rs2    = ~b;
      bus.funct3 = ~f3;
      bus.dest   = ~d;
   endtask

   // Issue one op and push its expected response.
   task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] d, input logic [31:0] res);
      waitIdle();
      bus.funct3 = f3;
      bus.rs1    = a;
      bus.rs2    = b;
      bus.dest   = d;
      bus.start  = 1'b1;
      exp_q.push_back('{res: res, dest: d, cyc: cyc + 34});
      last_res   = res;
      last_dest  = d;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.rs1    = ~a;
      bus.rs2    = ~b;
      bus.funct3 = ~f3;
      bus.dest   = ~d;
   endtask

   // Monitor: on every falling edge check the done pulse width and, when done
   // is high, pop the oldest expectation and compare the response with it.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (prev_done === 1'b1) checkOutput("done_pulse", 32'(bus.done), 32'd0);
         if (bus.done === 1'b1) begin
            checkOutput("pending_op", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checkOutput("result", bus.result, e.res);
               checkOutput("dest_out", 32'(bus.dest_out), 32'(e.dest));
               checkOutput("wr_en", 32'(bus.wr_en), 32'd1);
               checkOutput("latency", 32'(cyc), 32'(e.cyc));
            end
         end
         prev_done = bus.done;
      end
   end

   // Directed stimulus.
   initial begin : driver
      int c0;
      int n;
      bus.start  = 1'b0;
      bus.kill   = 1'b0;
      bus.funct3 = '0;
      bus.rs1    = '0;
      bus.rs2    = '0;
      bus.dest   = '0;
      rst        = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_done", 32'(bus.done), 32'd0);
      checkOutput("rst_wr_en", 32'(bus.wr_en), 32'd0);
      checkOutput("rst_result", bus.result, 32'd0);
      checkOutput("rst_dest_out", 32'(bus.dest_out), 32'd0);
      rst = 1'b1;
      $display("[TB] reset released");

      applyStimulus(FUNCT3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
      applyStimulus(FUNCT3_MULH,   32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000);
      applyStimulus(FUNCT3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE);
      applyStimulus(FUNCT3_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd8,  32'hFFFF_FFFF);
      applyStimulus(FUNCT3_MUL,    32'h8000_0000,  32'hFFFF_FFFF, 5'd9,  32'h8000_0000);
      applyStimulus(FUNCT3_MULH,   32'h8000_0000,  32'hFFFF_FFFF, 5'd4,  32'h0000_0000);
      applyStimulus(FUNCT3_DIVU,   32'd100,        32'd7,         5'd10, 32'd14);
      applyStimulus(FUNCT3_REMU,   32'd100,        32'd7,         5'd11, 32'd2);
      applyStimulus(FUNCT3_DIV,    32'hFFFF_FF9C,  32'd7,         5'd12, 32'hFFFF_FFF2);
      applyStimulus(FUNCT3_REM,    32'hFFFF_FF9C,  32'd7,         5'd13, 32'hFFFF_FFFE);
      applyStimulus(FUNCT3_DIV,    32'h0000_1234,  32'd0,         5'd14, 32'hFFFF_FFFF);
      applyStimulus(FUNCT3_REMU,   32'h0000_1234,  32'd0,         5'd15, 32'h0000_1234);
      applyStimulus(FUNCT3_REM,    32'hFFFF_FF9C,  32'd0,         5'd18, 32'hFFFF_FF9C);
      applyStimulus(FUNCT3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'h8000_0000);
      applyStimulus(FUNCT3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd17, 32'h0000_0000);

      $display("[TB] start while busy");
      applyStimulus(FUNCT3_DIVU, 32'd1000, 32'd10, 5'd19, 32'd100);
      repeat (4) @(negedge clk);
      bus.funct3 = FUNCT3_MUL;
      bus.rs1    = 32'd3;
      bus.rs2    = 32'd3;
      bus.dest   = 5'd1;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start  = 1'b0;

      $display("[TB] kill during CALC");
      issueRaw(FUNCT3_MUL, 32'd5, 32'd6, 5'd3, c0);
      n = 0;
      while (cyc < c0 + 10 && n < 100) begin
         @(negedge clk);
         n++;
      end
      bus.kill = 1'b1;
      @(negedge clk);
      bus.kill = 1'b0;
      checkOutput("kill_busy", 32'(bus.busy), 32'd0);
      repeat (40) @(negedge clk);
      checkOutput("kill_result", bus.result, last_res);
      checkOutput("kill_dest_out", 32'(bus.dest_out), 32'(last_dest));

      $display("[TB] kill with start");
      waitIdle();
      bus.funct3 = FUNCT3_DIVU;
      bus.rs1    = 32'd50;
      bus.rs2    = 32'd5;
      bus.dest   = 5'd2;
      bus.start  = 1'b1;
      bus.kill   = 1'b1;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.kill   = 1'b0;
      checkOutput("kill_start_busy", 32'(bus.busy), 32'd0);
      repeat (40) @(negedge clk);

      $display("[TB] reset mid-op");
      issueRaw(FUNCT3_DIVU, 32'h0000_FFFF, 32'd3, 5'd7, c0);
      n = 0;
      while (cyc < c0 + 20 && n < 100) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
      checkOutput("midrst_done", 32'(bus.done), 32'd0);
      checkOutput("midrst_wr_en", 32'(bus.wr_en), 32'd0);
      checkOutput("midrst_result", bus.result, 32'd0);
      checkOutput("midrst_dest_out", 32'(bus.dest_out), 32'd0);
      rst = 1'b1;
      repeat (40) @(negedge clk);

      applyStimulus(FUNCT3_REM, 32'h7FFF_FFFF, 32'd16, 5'd12, 32'd15);

      n = 0;
      while (exp_q.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain", 32'(exp_q.size()), 32'd0);
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
